// File: rtl/iahb_arb_pkg.sv
// Shared types for the instruction-bus arbiter: HTRANS codes, port state, captured request.
package iahb_arb_pkg;

    localparam int REQ_ADDR_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        PORT_IDLE = 2'b00,
        PORT_PEND = 2'b01,
        PORT_DATA = 2'b10
    } port_state_t;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [3:0]            prot;
    } req_t;

endpackage

// File: rtl/iahb_arb_if.sv
// One AHB-Lite link; the arbiter takes each master link as slave and drives the memory link as master.
interface iahb_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/iahb_arb_port.sv
// Per-master port: IDLE/PEND/DATA state, holding register for a losing address phase.
// Latency: state changes on the edge after issue/capture; hready/hresp are combinational.
// Backpressure: hready low while PEND, follows slave hready while owning the data phase.
module iahb_arb_port
    import iahb_arb_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_resetn,
    input  req_t        live_req,
    input  logic        issue,
    input  logic        capture,
    input  logic        s_hready,
    input  logic        s_hresp,
    output port_state_t state,
    output req_t        held_req,
    output logic        hready,
    output logic        hresp
);

    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            state    <= PORT_IDLE;
            held_req <= '0;
        end else if (issue) begin
            state <= PORT_DATA;
        end else if (capture) begin
            state    <= PORT_PEND;
            held_req <= live_req;
        end else if (state == PORT_DATA && s_hready) begin
            state <= PORT_IDLE;
        end
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        case (state)
            PORT_DATA: begin
                hready = s_hready;
                hresp  = s_hresp;
            end
            PORT_PEND: hready = 1'b0;
            default:   hready = 1'b1;
        endcase
    end

endmodule

// File: rtl/iahb_arbiter.sv
// Two-master AHB-Lite arbiter in front of the instruction memory, round-robin on ties.
// Latency: zero added cycles uncontended; a loser is replayed in the next free slave slot.
// Backpressure: slave hready stalls the owner and any pending port; nothing issues while low.
module iahb_arbiter
    import iahb_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic sys_clk,
    input  logic sys_resetn,
    iahb_arb_if.slave  m0,
    iahb_arb_if.slave  m1,
    iahb_arb_if.master s
);

    req_t        live0, live1, held0, held1, chosen;
    port_state_t st0, st1;
    logic        hready0, hready1, hresp0, hresp1;
    logic [1:0]  acc, issue, capture;
    logic        issue_vld, sel, replay;
    logic        last_grant, owner, owner_vld;

    assign live0 = {m0.haddr, m0.hwrite, m0.hsize, m0.hburst, m0.hprot};
    assign live1 = {m1.haddr, m1.hwrite, m1.hsize, m1.hburst, m1.hprot};

    // Reset gates acceptance so nothing reaches the slave while sys_resetn is low.
    assign acc[0] = sys_resetn & hready0 & m0.htrans[1];
    assign acc[1] = sys_resetn & hready1 & m1.htrans[1];

    always_comb begin
        issue_vld = 1'b0;
        sel       = 1'b0;
        replay    = 1'b0;
        if (sys_resetn && s.hready) begin
            if (st0 == PORT_PEND) begin
                issue_vld = 1'b1;
                replay    = 1'b1;
            end else if (st1 == PORT_PEND) begin
                issue_vld = 1'b1;
                replay    = 1'b1;
                sel       = 1'b1;
            end else if (acc[0] && acc[1]) begin
                issue_vld = 1'b1;
                sel       = ~last_grant;
            end else if (acc[0]) begin
                issue_vld = 1'b1;
            end else if (acc[1]) begin
                issue_vld = 1'b1;
                sel       = 1'b1;
            end
        end
    end

    assign issue[0]   = issue_vld & ~sel;
    assign issue[1]   = issue_vld &  sel;
    assign capture    = acc & ~issue;

    assign chosen = replay ? (sel ? held1 : held0) : (sel ? live1 : live0);

    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            owner_vld  <= 1'b0;
        end else if (issue_vld) begin
            last_grant <= sel;
            owner      <= sel;
            owner_vld  <= 1'b1;
        end else if (s.hready) begin
            owner_vld  <= 1'b0;
        end
    end

    assign s.htrans = issue_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s.haddr  = chosen.addr;
    assign s.hwrite = chosen.write;
    assign s.hsize  = chosen.size;
    assign s.hburst = chosen.burst;
    assign s.hprot  = chosen.prot;
    assign s.hwdata = !owner_vld ? '0 : (owner ? m1.hwdata : m0.hwdata);

    assign m0.hrdata = s.hrdata;
    assign m1.hrdata = s.hrdata;
    assign m0.hready = hready0;
    assign m1.hready = hready1;
    assign m0.hresp  = hresp0;
    assign m1.hresp  = hresp1;

    iahb_arb_port u_port0 (
        .sys_clk    (sys_clk),
        .sys_resetn (sys_resetn),
        .live_req   (live0),
        .issue      (issue[0]),
        .capture    (capture[0]),
        .s_hready   (s.hready),
        .s_hresp    (s.hresp),
        .state      (st0),
        .held_req   (held0),
        .hready     (hready0),
        .hresp      (hresp0)
    );

    iahb_arb_port u_port1 (
        .sys_clk    (sys_clk),
        .sys_resetn (sys_resetn),
        .live_req   (live1),
        .issue      (issue[1]),
        .capture    (capture[1]),
        .s_hready   (s.hready),
        .s_hresp    (s.hresp),
        .state      (st1),
        .held_req   (held1),
        .hready     (hready1),
        .hresp      (hresp1)
    );

endmodule

// File: tb/tb_iahb_arbiter.sv
// Directed bench for iahb_arbiter: the bench plays both masters and the memory slave.
module tb_iahb_arbiter;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    iahb_arb_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
    iahb_arb_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
    iahb_arb_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

    iahb_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .sys_clk    (clk),
        .sys_resetn (resetn),
        .m0         (m0_bus),
        .m1         (m1_bus),
        .s          (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic [31:0] addr, input logic wr);
        m0_bus.htrans = 2'b10;
        m0_bus.haddr  = addr;
        m0_bus.hwrite = wr;
    endtask

    task automatic req1(input logic [31:0] addr, input logic wr);
        m1_bus.htrans = 2'b10;
        m1_bus.haddr  = addr;
        m1_bus.hwrite = wr;
    endtask

    // Inputs change just after the falling edge; checks follow 1ns later, well before the rising edge.
    task automatic next_cyc;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn = 1'b0;
        m0_bus.htrans = 2'b00; m0_bus.haddr = '0; m0_bus.hwrite = 1'b0;
        m0_bus.hsize = 3'b010; m0_bus.hburst = 3'b000; m0_bus.hprot = 4'b0011; m0_bus.hwdata = '0;
        m1_bus.htrans = 2'b00; m1_bus.haddr = '0; m1_bus.hwrite = 1'b0;
        m1_bus.hsize = 3'b010; m1_bus.hburst = 3'b000; m1_bus.hprot = 4'b0001; m1_bus.hwdata = '0;
        s_bus.hready = 1'b1; s_bus.hresp = 1'b0; s_bus.hrdata = '0;

        next_cyc; next_cyc;
        resetn = 1'b1;
        #1;
        chk("rst_htrans", 32'(s_bus.htrans), 32'h0);
        chk("rst_m0_hready", 32'(m0_bus.hready), 32'h1);
        chk("rst_m1_hready", 32'(m1_bus.hready), 32'h1);
        chk("rst_m0_hresp", 32'(m0_bus.hresp), 32'h0);
        chk("rst_m1_hresp", 32'(m1_bus.hresp), 32'h0);

        // Simultaneous requests after reset: m0 wins, m1 replayed next slot.
        next_cyc;
        req0(32'h200, 1'b0);
        req1(32'h300, 1'b1);
        #1;
        chk("sim_htrans0", 32'(s_bus.htrans), 32'h2);
        chk("sim_haddr0", s_bus.haddr, 32'h200);
        chk("sim_hwrite0", 32'(s_bus.hwrite), 32'h0);
        chk("sim_m1_hready0", 32'(m1_bus.hready), 32'h1);
        next_cyc;
        m0_bus.htrans = 2'b00;
        s_bus.hrdata = 32'hAAAA0200;
        #1;
        chk("sim_m1_pend_hready", 32'(m1_bus.hready), 32'h0);
        chk("sim_m0_hready", 32'(m0_bus.hready), 32'h1);
        chk("sim_m0_hrdata", m0_bus.hrdata, 32'hAAAA0200);
        chk("sim_replay_htrans", 32'(s_bus.htrans), 32'h2);
        chk("sim_replay_haddr", s_bus.haddr, 32'h300);
        chk("sim_replay_hwrite", 32'(s_bus.hwrite), 32'h1);
        chk("sim_replay_hprot", 32'(s_bus.hprot), 32'h1);
        next_cyc;
        m1_bus.htrans = 2'b00;
        m1_bus.hwdata = 32'hDEADBEEF;
        #1;
        chk("sim_hwdata", s_bus.hwdata, 32'hDEADBEEF);
        chk("sim_m1_hready_data", 32'(m1_bus.hready), 32'h1);
        chk("sim_idle_htrans", 32'(s_bus.htrans), 32'h0);

        // Round-robin: continuous contention alternates m0, m1, m0, m1.
        next_cyc;
        req0(32'h400, 1'b0);
        req1(32'h500, 1'b0);
        #1;
        chk("rr_slot1", s_bus.haddr, 32'h400);
        next_cyc;
        req0(32'h404, 1'b0);
        #1;
        chk("rr_slot2", s_bus.haddr, 32'h500);
        chk("rr_slot2_m1_hready", 32'(m1_bus.hready), 32'h0);
        next_cyc;
        req1(32'h504, 1'b0);
        #1;
        chk("rr_slot3", s_bus.haddr, 32'h404);
        chk("rr_slot3_m0_hready", 32'(m0_bus.hready), 32'h0);
        next_cyc;
        m0_bus.htrans = 2'b00;
        #1;
        chk("rr_slot4", s_bus.haddr, 32'h504);
        chk("rr_slot4_htrans", 32'(s_bus.htrans), 32'h2);
        next_cyc;
        m1_bus.htrans = 2'b00;
        #1;
        chk("rr_done_htrans", 32'(s_bus.htrans), 32'h0);

        // Uncontended fetch: same-cycle forwarding, data the next cycle.
        next_cyc;
        req0(32'h100, 1'b0);
        #1;
        chk("unc_haddr", s_bus.haddr, 32'h100);
        chk("unc_htrans", 32'(s_bus.htrans), 32'h2);
        chk("unc_m1_hready", 32'(m1_bus.hready), 32'h1);
        next_cyc;
        m0_bus.htrans = 2'b00;
        s_bus.hrdata = 32'h12345678;
        #1;
        chk("unc_m0_hrdata", m0_bus.hrdata, 32'h12345678);
        chk("unc_m0_hready", 32'(m0_bus.hready), 32'h1);
        chk("unc_m1_hready2", 32'(m1_bus.hready), 32'h1);

        // Wait states: m1 wins the tie (last grant m0), m0 pends through 3 waits.
        next_cyc;
        req0(32'h600, 1'b0);
        req1(32'h700, 1'b1);
        #1;
        chk("ws_first_grant", s_bus.haddr, 32'h700);
        next_cyc;
        m1_bus.htrans = 2'b00;
        m1_bus.hwdata = 32'hCAFEF00D;
        s_bus.hready = 1'b0;
        #1;
        chk("ws_w1_m0_hready", 32'(m0_bus.hready), 32'h0);
        chk("ws_w1_m1_hready", 32'(m1_bus.hready), 32'h0);
        chk("ws_w1_htrans", 32'(s_bus.htrans), 32'h0);
        next_cyc;
        #1;
        chk("ws_w2_m0_hready", 32'(m0_bus.hready), 32'h0);
        chk("ws_w2_htrans", 32'(s_bus.htrans), 32'h0);
        next_cyc;
        #1;
        chk("ws_w3_m0_hready", 32'(m0_bus.hready), 32'h0);
        chk("ws_w3_hwdata", s_bus.hwdata, 32'hCAFEF00D);
        next_cyc;
        s_bus.hready = 1'b1;
        #1;
        chk("ws_w4_m0_hready", 32'(m0_bus.hready), 32'h0);
        chk("ws_w4_htrans", 32'(s_bus.htrans), 32'h2);
        chk("ws_w4_haddr", s_bus.haddr, 32'h600);
        chk("ws_w4_m1_hready", 32'(m1_bus.hready), 32'h1);
        next_cyc;
        m0_bus.htrans = 2'b00;
        s_bus.hrdata = 32'h0000A600;
        #1;
        chk("ws_m0_hready_after", 32'(m0_bus.hready), 32'h1);
        chk("ws_m0_hrdata", m0_bus.hrdata, 32'h0000A600);

        // Two-cycle ERROR on an m0 read reaches m0 only.
        next_cyc;
        req0(32'h800, 1'b0);
        #1;
        chk("err_issue", s_bus.haddr, 32'h800);
        next_cyc;
        m0_bus.htrans = 2'b00;
        s_bus.hready = 1'b0;
        s_bus.hresp = 1'b1;
        #1;
        chk("err_c1_m0_hresp", 32'(m0_bus.hresp), 32'h1);
        chk("err_c1_m0_hready", 32'(m0_bus.hready), 32'h0);
        chk("err_c1_m1_hresp", 32'(m1_bus.hresp), 32'h0);
        chk("err_c1_m1_hready", 32'(m1_bus.hready), 32'h1);
        next_cyc;
        s_bus.hready = 1'b1;
        #1;
        chk("err_c2_m0_hresp", 32'(m0_bus.hresp), 32'h1);
        chk("err_c2_m0_hready", 32'(m0_bus.hready), 32'h1);
        chk("err_c2_m1_hresp", 32'(m1_bus.hresp), 32'h0);
        next_cyc;
        s_bus.hresp = 1'b0;
        #1;
        chk("err_after_m0_hresp", 32'(m0_bus.hresp), 32'h0);

        // Reset while m1 is pending behind a stalled m0 transfer.
        next_cyc;
        req0(32'h900, 1'b0);
        #1;
        chk("rm_m0_issue", s_bus.haddr, 32'h900);
        next_cyc;
        m0_bus.htrans = 2'b00;
        s_bus.hready = 1'b0;
        req1(32'hA00, 1'b0);
        #1;
        chk("rm_stall_htrans", 32'(s_bus.htrans), 32'h0);
        next_cyc;
        resetn = 1'b0;
        #1;
        chk("rm_m1_pend_hready", 32'(m1_bus.hready), 32'h0);
        next_cyc;
        #1;
        chk("rm_htrans", 32'(s_bus.htrans), 32'h0);
        chk("rm_m0_hready", 32'(m0_bus.hready), 32'h1);
        chk("rm_m1_hready", 32'(m1_bus.hready), 32'h1);
        next_cyc;
        resetn = 1'b1;
        s_bus.hready = 1'b1;
        req0(32'hB00, 1'b0);
        req1(32'hC00, 1'b0);
        #1;
        chk("rm_tie_after_reset", s_bus.haddr, 32'hB00);
        next_cyc;
        m0_bus.htrans = 2'b00;
        m1_bus.htrans = 2'b00;
        next_cyc;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/iahb_arbiter.md
# iahb_arbiter

Two-master AHB-Lite arbiter that shares the instruction-bus memory (`cpu_mem`) between the E902 instruction port (master 0) and a program loader/debug master (master 1). It sits between the core's `iahbl_pad_*` bus, the loader, and the single `cpu_mem` slave in `soc`. Transfers are forwarded with no added latency when uncontended. A losing address phase is captured and replayed, with round-robin fairness.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `sys_clk` in 1: single clock for all logic
- `sys_resetn` in 1: reset, synchronous and active-low
- `m0_haddr` / `m1_haddr` in ADDR_W: master address
- `m0_htrans` / `m1_htrans` in 2: transfer type; bit 1 set means a transfer is requested
- `m0_hwrite` / `m1_hwrite` in 1: write
- `m0_hsize` / `m1_hsize` in 3: size
- `m0_hburst` / `m1_hburst` in 3: burst (passed through; SINGLE only)
- `m0_hprot` / `m1_hprot` in 4: protection
- `m0_hwdata` / `m1_hwdata` in DATA_W: write data
- `m0_hrdata` / `m1_hrdata` out DATA_W: read data (the slave's `s_hrdata`, fanned out to both)
- `m0_hready` / `m1_hready` out 1: per-master ready
- `m0_hresp` / `m1_hresp` out 1: per-master response (0 OKAY, 1 ERROR)
- `s_haddr`, `s_htrans`, `s_hwrite`, `s_hsize`, `s_hburst`, `s_hprot`, `s_hwdata` out: slave-side request
- `s_hrdata` in DATA_W, `s_hready` in 1, `s_hresp` in 1: slave response

## Operation
- Each master port has state IDLE, PEND or DATA.
  - PEND: address phase captured in a holding register, not yet issued to the slave.
  - DATA: this master owns the slave's current data phase.
- Master address phase is accepted when `mX_hready`=1 and `mX_htrans[1]`=1.
- Slave address slot is free when `s_hready`=1. Selection order in a free slot:
  1. The pending master, if any.
  2. The live requester.
  3. With two live requesters, the one that is not `last_grant`.
- An accepted but unselected request is captured (addr, write, size, burst, prot) and its port goes to PEND.
  - At most one port is PEND at any time.
- Issued request: the selected port goes to DATA on the next edge; `last_grant` is updated; the data-phase owner register is set.
- `s_htrans` = NONSEQ when a request is issued, IDLE otherwise. `s_haddr` and the control outputs come from the holding register when replaying, else from the live master.
- `s_hwdata` is muxed by the data-phase owner. A PEND master still holds its write data because its `hready` is low.
- `mX_hready`:
  - port in DATA: equals `s_hready`
  - port in PEND: 0
  - otherwise: 1
- `mX_hresp`: equals `s_hresp` when port is DATA, else 0. A two-cycle ERROR passes through unchanged to the owner only.
- DATA→IDLE when `s_hready`=1 and no new request is issued for that port. DATA→DATA when the same master issues back-to-back.
- Reset (synchronous, `sys_resetn`=0 at an edge):
  - all ports IDLE, no owner, `last_grant`=1 (so master 0 wins the first tie)
  - `s_htrans`=IDLE, `mX_hready`=1, `mX_hresp`=0
  - in-flight transfers are abandoned

## Timing
- Uncontended: combinational path master→slave, zero added cycles.
- Contended: loser waits exactly one slave data phase. It is replayed in the first cycle with `s_hready`=1 after capture.
- Pending beats a new request from the other master in the same cycle (no starvation).
- Slave wait states: `s_hready`=0 stalls the owner and holds any PEND. Nothing new is issued.
- Owner issues its next NONSEQ while the other master is PEND: the owner's request is captured as PEND only after the existing PEND is issued. Because its `hready` equals `s_hready`, it is accepted in the replay cycle, so the arbiter replays first and the owner becomes PEND.
- ERROR first cycle (`s_hready`=0): no issue. Second cycle (`s_hready`=1): normal slot; PEND may be issued.

## Structure
- Package `iahb_arb_pkg`:
  - HTRANS encodings (IDLE 2'b00, NONSEQ 2'b10)
  - port state enum
  - request struct `{addr, write, size, burst, prot}`
- Sub-module `iahb_arb_port`, instantiated twice: state register, holding register, `hready`/`hresp` generation.
- Top: selection logic, `last_grant`, data-phase owner register, slave muxes.

## Test plan
- Uncontended fetch: m0 NONSEQ read 0x100, slave 0-wait → `s_haddr`=0x100 in the same cycle; `m0_hrdata` valid next cycle; `m1_hready` stays 1.
- Simultaneous after reset: m0 read 0x200 and m1 write 0x300 with data 0xDEADBEEF.
  - m0 is issued first; m1 goes PEND with `m1_hready`=0 for one data phase.
  - 0x300 is then issued and `s_hwdata`=0xDEADBEEF in its data phase.
- Round-robin: repeated simultaneous requests alternate grants m0, m1, m0, m1 over 4 slots.
- Wait states: slave inserts 3 wait cycles on m1 write while m0 is PEND → m0 `hready`=0 for 4 cycles; m0 issued on the 4th.
- ERROR: slave returns two-cycle ERROR to m0 → `m0_hresp`=1 for both cycles, `m0_hready` 0 then 1; `m1_hresp` stays 0.
- Reset mid-transfer: `sys_resetn`=0 while m1 is PEND → next edge `s_htrans`=IDLE, both `hready`=1, `last_grant`=1.
